// File: rtl/led_strip_pkg.sv
// led_strip_pkg: shared FSM states, frame constants and APA102 pixel word helper
package led_strip_pkg;
  typedef enum logic [2:0] {IDLE, START_F, PIXEL, END_F, DONE} state_t;
  localparam int START_BITS = 32;
  localparam int WORD_W = 32;
  localparam logic [2:0] APA_HDR = 3'b111;
  function automatic logic [WORD_W-1:0] apa_word(input logic [4:0] bri, input logic [7:0] b,
                                                 input logic [7:0] g, input logic [7:0] r);
    return {APA_HDR, bri, b, g, r};
  endfunction
endpackage

// File: rtl/led_bit_timer.sv
// led_bit_timer: bit phase generator (clk, reset, en -> led_clk low then high CLK_DIV cycles each, bit_start/bit_end strobes; en=0 stalls)
module led_bit_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic led_clk,
  output logic bit_start,
  output logic bit_end
);
  logic [7:0] phase;
  logic last;
  assign last = phase == 8'(CLK_DIV - 1);
  assign bit_start = en && !led_clk && phase == 8'd0;
  assign bit_end = en && led_clk && last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= '0;
      led_clk <= 1'b0;
    end else if (en) begin
      phase <= last ? '0 : phase + 8'd1;
      led_clk <= led_clk ^ last;
    end
endmodule

// File: rtl/led_strip_tx.sv
// led_strip_tx: APA102 frame serializer (clk, reset, start, pix_data/pix_valid/pix_ready in, busy/frame_done/led_clk/led_data out)
module led_strip_tx
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS = 64,
  parameter int CLK_DIV = 1,
  parameter int END_BITS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        led_clk,
  output logic        led_data
);
  localparam int WCW = $clog2(NUM_LEDS + 1);
  state_t state, state_n;
  logic [WORD_W-1:0] hold, sh;
  logic hold_full, sh_full, en, load, bit_start, bit_end, word_end, all_in;
  logic [$clog2(START_BITS)-1:0] bit_cnt;
  logic [WCW-1:0] words;
  logic [7:0] end_cnt;
  led_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(en),
    .led_clk(led_clk),
    .bit_start(bit_start),
    .bit_end(bit_end)
  );
  assign word_end = bit_end && bit_cnt == '0;
  assign all_in = words == WCW'(NUM_LEDS);
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    frame_done = state == DONE;
    en = state == START_F || state == END_F || (state == PIXEL && sh_full);
    pix_ready = busy && !hold_full && !all_in;
    led_data = state == PIXEL && sh_full && sh[WORD_W-1];
    load = hold_full && ((state == START_F && word_end) || (state == PIXEL && (word_end || !sh_full)));
    case (state)
      IDLE:    state_n = start ? START_F : IDLE;
      START_F: state_n = word_end ? PIXEL : START_F;
      PIXEL:   state_n = word_end && !hold_full && all_in ? END_F : PIXEL;
      END_F:   state_n = bit_end && end_cnt == 8'(END_BITS) ? DONE : END_F;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      sh <= '0;
      hold_full <= 1'b0;
      sh_full <= 1'b0;
      bit_cnt <= '0;
      words <= '0;
      end_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) words <= '0;
      else if (pix_valid && pix_ready) words <= words + 1'b1;
      if (pix_valid && pix_ready) begin
        hold <= pix_data;
        hold_full <= 1'b1;
      end else if (load) hold_full <= 1'b0;
      if (load) begin
        sh <= hold;
        sh_full <= 1'b1;
      end else if (state == PIXEL && bit_end) begin
        sh <= sh << 1;
        sh_full <= !word_end;
      end
      if (bit_start && state != END_F) bit_cnt <= bit_cnt + 1'b1;
      if (state == DONE) end_cnt <= '0;
      else if (bit_start && state == END_F) end_cnt <= end_cnt + 8'd1;
    end
endmodule

// File: tb/tb_led_strip_tx.sv
// tb_led_strip_tx: scoreboard bench for led_strip_tx across three parameter sets
module tb_led_strip_tx;
  import led_strip_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic [31:0] pix_data = 32'h0;
  logic [1:0] sel = 2'd0;
  logic [2:0] pr, bz, fd, lc, ld;
  logic m_pr, m_bz, m_fd, m_lc, m_ld;
  int n_chk = 0, n_fail = 0, edges = 0, hs = 0, src_n = 0, cyc = 0, cdiv = 1;
  int gate_word = -1, gate_cyc = 0, e_base = 0, h_base = 0;
  logic [31:0] src_q[$];
  logic exp_q[$];
  assign m_pr = pr[sel];
  assign m_bz = bz[sel];
  assign m_fd = fd[sel];
  assign m_lc = lc[sel];
  assign m_ld = ld[sel];
  always #5 clk = ~clk;
  led_strip_tx #(.NUM_LEDS(2), .CLK_DIV(1), .END_BITS(8)) u0 (
    .clk(clk), .reset(reset), .start(start && sel == 2'd0), .pix_data(pix_data),
    .pix_valid(pix_valid && sel == 2'd0), .pix_ready(pr[0]), .busy(bz[0]),
    .frame_done(fd[0]), .led_clk(lc[0]), .led_data(ld[0]));
  led_strip_tx #(.NUM_LEDS(2), .CLK_DIV(3), .END_BITS(8)) u1 (
    .clk(clk), .reset(reset), .start(start && sel == 2'd1), .pix_data(pix_data),
    .pix_valid(pix_valid && sel == 2'd1), .pix_ready(pr[1]), .busy(bz[1]),
    .frame_done(fd[1]), .led_clk(lc[1]), .led_data(ld[1]));
  led_strip_tx #(.NUM_LEDS(64), .CLK_DIV(1), .END_BITS(64)) u2 (
    .clk(clk), .reset(reset), .start(start && sel == 2'd2), .pix_data(pix_data),
    .pix_valid(pix_valid && sel == 2'd2), .pix_ready(pr[2]), .busy(bz[2]),
    .frame_done(fd[2]), .led_clk(lc[2]), .led_data(ld[2]));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pix_word(input int i);
    return i == 0 ? 32'hE0FF0000 : i == 1 ? 32'hFF00FF00 :
           apa_word(5'(i), 8'(i * 5), 8'(255 - i), 8'(i * 11));
  endfunction
  task automatic queue_frame(input int n, input int endb);
    logic [31:0] w;
    for (int i = 0; i < START_BITS; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      w = pix_word(i);
      src_q.push_back(w);
      for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
    end
    for (int i = 0; i < endb; i++) exp_q.push_back(1'b0);
  endtask
  task automatic begin_frame(input int hold_cyc, output int t0);
    e_base = edges;
    h_base = hs;
    t0 = -1;
    start = 1'b1;
    for (int i = 0; i < hold_cyc; i++) begin
      tick();
      if (i == 0) begin
        chk("busy_rise", int'(m_bz), 1);
        t0 = cyc;
      end
    end
    start = 1'b0;
  endtask
  task automatic end_frame(input int t0, input int len, input int n_edges, input int n_words, output int td);
    int w;
    w = 0;
    while (!m_fd && w < 20000) begin
      tick();
      w++;
    end
    td = cyc;
    chk("frame_len", td - t0, len);
    chk("edge_count", edges - e_base, n_edges);
    chk("handshakes", hs - h_base, n_words);
    tick();
    chk("done_pulse_width", int'(m_fd), 0);
    chk("busy_after_done", int'(m_bz), 0);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    logic x;
    forever begin
      @(negedge clk);
      x = pix_valid && m_pr;
      tick();
      if (x && src_q.size() > 0) begin
        void'(src_q.pop_front());
        hs++;
        src_n++;
      end
      pix_valid = src_q.size() > 0 && (src_n != gate_word || cyc >= gate_cyc);
      pix_data = src_q.size() > 0 ? src_q[0] : 32'h0;
    end
  end
  initial begin
    logic prev, held, e;
    int hi_run;
    prev = 1'b0;
    held = 1'b0;
    hi_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        hi_run = 0;
      end else begin
        if (m_lc && !prev) begin
          edges++;
          held = m_ld;
          chk("edge_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("serial_bit", int'(m_ld), int'(e));
          end
        end else if (m_lc) chk("data_stable_high", int'(m_ld), int'(held));
        if (m_lc) hi_run++;
        if (!m_lc && prev) begin
          chk("high_phase_width", hi_run, cdiv);
          hi_run = 0;
        end
        prev = m_lc;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, t1, td, w, seen;
    repeat (3) tick();
    chk("rst_led_clk", int'(m_lc), 0);
    chk("rst_led_data", int'(m_ld), 0);
    chk("rst_busy", int'(m_bz), 0);
    chk("rst_pix_ready", int'(m_pr), 0);
    chk("rst_frame_done", int'(m_fd), 0);
    reset = 1'b0;
    queue_frame(2, 8);
    repeat (3) tick();
    chk("idle_ready_low", int'(m_pr), 0);
    chk("idle_no_handshake", hs, 0);
    begin_frame(1, t0);
    end_frame(t0, 208, 104, 2, td);
    chk("sb_drained_basic", exp_q.size(), 0);
    gate_word = src_n + 1;
    gate_cyc = 32'h4000_0000;
    queue_frame(2, 8);
    begin_frame(1, t0);
    gate_cyc = t0 + 136;
    while (cyc < t0 + 128) tick();
    chk("stall_data_low", int'(m_ld), 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_clk_low", int'(m_lc), 0);
      tick();
    end
    end_frame(t0, 218, 104, 2, td);
    chk("sb_drained_stall", exp_q.size(), 0);
    gate_word = -1;
    queue_frame(2, 8);
    src_q.push_back(32'hDEADBEEF);
    begin_frame(3, t0);
    while (cyc < t0 + 80) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    end_frame(t0, 208, 104, 2, td);
    seen = 0;
    repeat (20) begin
      tick();
      if (m_bz || m_fd || m_pr) seen++;
    end
    chk("no_second_frame", seen, 0);
    chk("no_extra_handshake", hs - h_base, 2);
    chk("sb_drained_ignore", exp_q.size(), 0);
    src_q.delete();
    tick();
    queue_frame(2, 8);
    begin_frame(1, t0);
    w = 0;
    while (edges - e_base < 50 && w < 1000) begin
      tick();
      w++;
    end
    while (!m_lc && w < 1000) begin
      tick();
      w++;
    end
    chk("pre_reset_clk_high", int'(m_lc), 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    src_q.delete();
    #1;
    chk("async_rst_led_clk", int'(m_lc), 0);
    chk("async_rst_led_data", int'(m_ld), 0);
    chk("async_rst_busy", int'(m_bz), 0);
    seen = 0;
    repeat (3) begin
      tick();
      if (m_fd) seen++;
    end
    reset = 1'b0;
    repeat (20) begin
      tick();
      if (m_fd || m_bz) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    queue_frame(2, 8);
    begin_frame(1, t0);
    end_frame(t0, 208, 104, 2, td);
    chk("sb_drained_after_reset", exp_q.size(), 0);
    sel = 2'd1;
    cdiv = 3;
    tick();
    queue_frame(2, 8);
    begin_frame(1, t0);
    end_frame(t0, 624, 104, 2, td);
    chk("sb_drained_div3", exp_q.size(), 0);
    sel = 2'd2;
    cdiv = 1;
    tick();
    queue_frame(64, 64);
    queue_frame(64, 64);
    begin_frame(1, t0);
    end_frame(t0, 4288, 2144, 64, td);
    begin_frame(1, t1);
    chk("back_to_back_gap", t1 - td, 2);
    end_frame(t1, 4288, 2144, 64, td);
    chk("sb_drained_b2b", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
- Downstream serializer for the LED-matrix pipeline.
- Accepts 32-bit per-LED colour words from the frame/scroll generator over a valid/ready handshake.
- Emits a serial clock/data stream to an APA102-style strip: 32-bit zero start frame, NUM_LEDS × 32 pixel bits, END_BITS zero end frame.
- Gives the display stage a clean frame-level interface, so that stage no longer bit-bangs the strip itself.

Parameters:
- NUM_LEDS, 64: pixel words per frame; 8x8 matrix.
- CLK_DIV, 1: clk cycles per led_clk phase; one bit lasts 2*CLK_DIV clk cycles. Range 1..255.
- END_BITS, 64: zero bits sent after the last pixel. Range 1..255.

Ports:
- clk  in  1  system clock; every sequential element runs on posedge clk.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to send a frame; honoured only when busy=0.
- pix_data  in  32  colour word, MSB transmitted first: {3'b111, brightness[4:0], blue, green, red}.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  block accepts pix_data this cycle. Transfer occurs when pix_valid & pix_ready.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last end-frame bit.
- led_clk  out  1  strip clock.
- led_data  out  1  strip data.

Behaviour:
- Reset values: led_clk=0, led_data=0, busy=0, pix_ready=0, frame_done=0. Holding register empty, all counters 0, state IDLE.
- Reset asserted mid-frame aborts the frame at once. No frame_done. led_clk drops to 0 asynchronously.
- States:
  - IDLE: start=1 → START_F. busy goes 1 the next cycle.
  - START_F: 32 zero bits → PIXEL.
  - PIXEL: NUM_LEDS words × 32 bits → END_F.
  - END_F: END_BITS zero bits → DONE.
  - DONE: single cycle; frame_done=1, busy=0 from the following cycle → IDLE.
- start while busy=1 is ignored; no queuing.
- Bit timing:
  - Each bit has a low phase (led_clk=0, led_data driven) of CLK_DIV cycles, then a high phase (led_clk=1, led_data held) of CLK_DIV cycles.
  - led_data changes only while led_clk=0, in the first cycle of a low phase. The strip samples on the rising edge.
- Pixel fetch:
  - One-word holding register. pix_ready = busy & !hold_full & (words_accepted < NUM_LEDS).
  - Prefetch starts in START_F, so a responsive source never stalls the stream.
  - At each pixel-word boundary, the shift register loads from the holding register.
- Underrun: if the holding register is empty at a word boundary, stall with led_clk=0 and led_data=0, with no bit counted, until a word arrives. The first bit goes out in the cycle after the load.
- Word accounting: words_accepted counts to exactly NUM_LEDS. pix_ready stays 0 afterwards and in IDLE/DONE. pix_valid in those states is ignored and left pending.
- Counters:
  - bit-in-word counter wraps 31→0.
  - word counter is $clog2(NUM_LEDS+1) bits.
  - end counter is 8 bits.
  - phase counter is 8 bits and wraps at CLK_DIV-1.
- Unstalled frame length = (32 + 32*NUM_LEDS + END_BITS) * 2*CLK_DIV cycles, from the first START_F cycle to the last END_F cycle.
- start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted, giving back-to-back frames.

Decomposition:
- Package led_strip_pkg holds:
  - state enum: IDLE, START_F, PIXEL, END_F, DONE.
  - START_BITS=32, WORD_W=32.
  - helper constant for the APA102 header 3'b111.
- One natural sub-module, led_bit_timer: phase counter plus led_clk generation.
  - Outputs bit_start (first low-phase cycle) and bit_end (last high-phase cycle).
  - Has an enable input; enable=0 stalls.
- Shift register, FSM and handshake stay in led_strip_tx.

Test Plan (NUM_LEDS=2, CLK_DIV=1, END_BITS=8 unless stated):
- Reset, then start with a source always valid supplying 32'hE0FF0000 and 32'hFF00FF00:
  - 104 led_clk rising edges.
  - Sampled bits: 32 zeros, E0FF0000 MSB-first, FF00FF00, then 8 zeros.
  - frame_done exactly 208 cycles after busy rises.
- Source withholds the second word for 10 cycles: led_clk stays 0 for those 10 cycles, bit sequence unchanged, frame_done 10 cycles later than the unstalled case.
- start pulsed again mid-frame, and start held high for 3 cycles: exactly one frame sent, no extra pix_ready.
- reset asserted at bit 50: led_clk, led_data and busy go 0 the same cycle. No frame_done. A fresh start afterwards sends a full correct frame.
- CLK_DIV=3: each led_clk phase is 3 cycles wide, led_data stable across every rising edge, frame_done 624 cycles after busy rises.
- NUM_LEDS=64, END_BITS=64, start pulsed in the first IDLE cycle after frame_done:
  - Exactly 64 handshakes per frame.
  - 2144 rising edges per frame.
  - Back-to-back frames with no gap beyond the DONE cycle and that one IDLE cycle.
